// File: rtl/sfq_pkg.sv
// Shared constants and helpers for the SFQ pulse channel.
// Defaults below are the parameter values the channel uses unless overridden.
package sfq_pkg;

  localparam int SFQ_PW     = 1;
  localparam int SFQ_TGATE  = 2;
  localparam int SFQ_TSETUP = 1;
  localparam int SFQ_THOLD  = 1;

  function automatic int sfq_cnt_w(input int pw);
    return $clog2(pw + 1);
  endfunction

  localparam int SFQ_CNT_W = sfq_cnt_w(SFQ_PW);

endpackage

// File: rtl/sfq_delay_line.sv
// Fixed-depth 1-bit pipeline; every input cycle reappears DEPTH cycles later.
// Used for both the gate delay and the propagation-delay strobe.
module sfq_delay_line
  import sfq_pkg::*;
#(
  parameter int DEPTH = SFQ_TGATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/sfq_modport_channel.sv
// One SFQ pulse channel: tx pulse generator, rx edge/flag logic,
// setup/hold checker against sfq_clk, and gate / tpd delay lines.
module sfq_modport_channel
  import sfq_pkg::*;
#(
  parameter int PW     = SFQ_PW,
  parameter int TGATE  = SFQ_TGATE,
  parameter int TSETUP = SFQ_TSETUP,
  parameter int THOLD  = SFQ_THOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tx_send,
  output logic data,
  output logic sent,
  output logic rx_pulse,
  input  logic rx_rd,
  output logic is_received,
  input  logic sfq_clk,
  output logic setup_viol,
  output logic hold_viol,
  input  logic gate_in,
  output logic gate_out,
  input  logic tpd_start,
  output logic tpd_done
);

  localparam int CW = sfq_cnt_w(PW);
  localparam int SW = (TSETUP > 0) ? TSETUP : 1;
  localparam int HW = (THOLD > 0) ? THOLD : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          sent_q;
  logic          sent_d;
  logic          rx_pulse_q;
  logic          rx_pulse_d;
  logic [SW-1:0] edge_hist_q;
  logic [SW-1:0] edge_hist_d;
  logic [HW-1:0] clk_hist_q;
  logic [HW-1:0] clk_hist_d;
  logic          start;

  always_comb begin
    // A send only starts a pulse from idle; mid-pulse sends just set the flag.
    start = tx_send && (cnt_q == '0);

    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CW'(PW);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end

    sent_d = sent_q;
    if (tx_send) begin
      sent_d = 1'b1;
    end else if (rx_rd) begin
      sent_d = 1'b0;
    end

    rx_pulse_d  = start;
    edge_hist_d = (edge_hist_q << 1) | SW'(rx_pulse_q);
    clk_hist_d  = (clk_hist_q << 1) | HW'(sfq_clk);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      sent_q      <= 1'b0;
      rx_pulse_q  <= 1'b0;
      edge_hist_q <= '0;
      clk_hist_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sent_q      <= sent_d;
      rx_pulse_q  <= rx_pulse_d;
      edge_hist_q <= edge_hist_d;
      clk_hist_q  <= clk_hist_d;
    end
  end

  assign data        = (cnt_q != '0);
  assign sent        = sent_q;
  assign is_received = sent_q;
  assign rx_pulse    = rx_pulse_q;

  // History holds only earlier cycles, so a same-cycle edge is hold-only.
  assign setup_viol = (TSETUP > 0) && sfq_clk && (|edge_hist_q);
  assign hold_viol  = rx_pulse_q &&
                      (sfq_clk || ((THOLD > 0) && (|clk_hist_q)));

  sfq_delay_line #(
    .DEPTH (TGATE)
  ) u_gate_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (gate_in),
    .dout (gate_out)
  );

  sfq_delay_line #(
    .DEPTH (TGATE)
  ) u_tpd_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (tpd_start),
    .dout (tpd_done)
  );

endmodule

// File: tb/tb_sfq_modport_channel.sv
// Scoreboard bench for sfq_modport_channel (PW=3, TGATE=2, TSETUP=THOLD=1).
// Expected output bits are queued per cycle when stimulus is driven.
module tb_sfq_modport_channel;

  logic clk = 1'b0;
  logic rst_n, tx_send, rx_rd, sfq_clk, gate_in, tpd_start;
  logic data, sent, rx_pulse, is_received;
  logic setup_viol, hold_viol, gate_out, tpd_done;
  logic [7:0] obs;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int   cyc;
    int   idx;
    logic val;
  } sb_t;

  sb_t   sb[$];
  string names[8] = '{"data", "sent", "rx_pulse", "is_received",
                      "setup_viol", "hold_viol", "gate_out", "tpd_done"};

  sfq_modport_channel #(
    .PW    (3),
    .TGATE (2),
    .TSETUP(1),
    .THOLD (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_send    (tx_send),
    .data       (data),
    .sent       (sent),
    .rx_pulse   (rx_pulse),
    .rx_rd      (rx_rd),
    .is_received(is_received),
    .sfq_clk    (sfq_clk),
    .setup_viol (setup_viol),
    .hold_viol  (hold_viol),
    .gate_in    (gate_in),
    .gate_out   (gate_out),
    .tpd_start  (tpd_start),
    .tpd_done   (tpd_done)
  );

  assign obs = {tpd_done, gate_out, hold_viol, setup_viol,
                is_received, rx_pulse, sent, data};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_at(input int c, input int idx, input logic v);
    sb.push_back('{c, idx, v});
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_at(input int c);
    goto(c);
    tx_send = 1'b1;
    goto(c + 1);
    tx_send = 1'b0;
  endtask

  task automatic sfq_at(input int c);
    goto(c);
    sfq_clk = 1'b1;
    goto(c + 1);
    sfq_clk = 1'b0;
  endtask

  task automatic rd_at(input int c);
    goto(c);
    rx_rd = 1'b1;
    goto(c + 1);
    rx_rd = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        chk($sformatf("%s@%0d", names[sb[i].idx], sb[i].cyc),
            {7'b0, obs[sb[i].idx]}, {7'b0, sb[i].val});
        sb.delete(i);
      end
    end
  end

  initial begin
    logic v;
    rst_n = 1'b0; tx_send = 1'b0; rx_rd = 1'b0;
    sfq_clk = 1'b0; gate_in = 1'b0; tpd_start = 1'b0;

    goto(2);
    chk("reset_state", obs, 8'h00);
    rst_n = 1'b1;

    // async reset in the middle of a pulse
    send_at(3);
    goto(4);
    chk("pre_rst_data", {7'b0, data}, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("rst_data", {7'b0, data}, 8'h00);
    chk("rst_sent", {7'b0, sent}, 8'h00);
    chk("rst_rx_pulse", {7'b0, rx_pulse}, 8'h00);
    goto(6);
    rst_n = 1'b1;

    // basic send
    goto(10);
    expect_at(10, 1, 1'b0);
    for (int c = 11; c <= 13; c++) expect_at(c, 0, 1'b1);
    expect_at(14, 0, 1'b0);
    expect_at(11, 2, 1'b1);
    expect_at(12, 2, 1'b0);
    expect_at(13, 2, 1'b0);
    expect_at(11, 1, 1'b1);
    send_at(10);

    // read-and-clear flags
    goto(16);
    expect_at(16, 3, 1'b1);
    expect_at(17, 1, 1'b0);
    expect_at(18, 3, 1'b0);
    rd_at(16);
    rd_at(18);

    // sticky sent without reads
    goto(20);
    for (int c = 21; c <= 40; c++) expect_at(c, 1, 1'b1);
    send_at(20);

    // set/clear collision
    goto(45);
    expect_at(45, 3, 1'b1);
    expect_at(46, 1, 1'b0);
    rd_at(45);
    goto(48);
    expect_at(48, 3, 1'b0);
    expect_at(49, 1, 1'b1);
    expect_at(49, 2, 1'b1);
    tx_send = 1'b1;
    rx_rd = 1'b1;
    goto(49);
    tx_send = 1'b0;
    rx_rd = 1'b0;

    // retrigger mid-pulse: one edge, no extension
    goto(55);
    expect_at(56, 2, 1'b1);
    expect_at(57, 2, 1'b0);
    expect_at(58, 2, 1'b0);
    expect_at(59, 2, 1'b0);
    expect_at(58, 0, 1'b1);
    expect_at(59, 0, 1'b0);
    send_at(55);
    send_at(57);

    // setup: edge 70, sfq_clk 71
    goto(69);
    expect_at(70, 4, 1'b0);
    expect_at(70, 5, 1'b0);
    expect_at(71, 4, 1'b1);
    expect_at(71, 5, 1'b0);
    send_at(69);
    sfq_at(71);

    // hold: sfq_clk 80, edge 81
    goto(80);
    expect_at(80, 4, 1'b0);
    expect_at(80, 5, 1'b0);
    expect_at(81, 5, 1'b1);
    sfq_clk = 1'b1;
    tx_send = 1'b1;
    goto(81);
    sfq_clk = 1'b0;
    tx_send = 1'b0;

    // far apart: edge 90, sfq_clk 95
    goto(89);
    expect_at(90, 5, 1'b0);
    expect_at(95, 4, 1'b0);
    send_at(89);
    sfq_at(95);

    // coincident: edge and sfq_clk at 100 -> hold only
    goto(99);
    expect_at(100, 5, 1'b1);
    expect_at(100, 4, 1'b0);
    send_at(99);
    sfq_at(100);

    // just outside the windows
    goto(109);
    expect_at(112, 4, 1'b0);
    expect_at(122, 5, 1'b0);
    send_at(109);
    sfq_at(112);
    sfq_at(120);
    send_at(121);

    // gate delay and tpd
    goto(130);
    expect_at(132, 6, 1'b1);
    expect_at(133, 6, 1'b0);
    expect_at(134, 6, 1'b1);
    expect_at(135, 6, 1'b1);
    expect_at(136, 6, 1'b0);
    expect_at(134, 7, 1'b0);
    expect_at(135, 7, 1'b1);
    expect_at(136, 7, 1'b1);
    expect_at(137, 7, 1'b0);
    gate_in = 1'b1;
    goto(131);
    gate_in = 1'b0;
    goto(132);
    gate_in = 1'b1;
    goto(133);
    tpd_start = 1'b1;
    goto(134);
    gate_in = 1'b0;
    goto(135);
    tpd_start = 1'b0;

    for (int c = 140; c < 160; c++) begin
      goto(c);
      v = 1'($urandom_range(0, 1));
      gate_in = v;
      expect_at(c + 2, 6, v);
    end
    goto(160);
    gate_in = 1'b0;
    expect_at(162, 6, 1'b0);

    goto(170);
    chk("sb_drain", 8'(sb.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
